// File: rtl/qsys_pio_pkg.sv
// Shared constants for the interrupting input PIO.
// Register map, edge-type codes and a width helper.
package qsys_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_DIR     = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Counter width for a debounce threshold n; never below one bit.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit: synchroniser chain followed by a
// stability counter that accepts a level after N clean clocks.
module pio_debounce_bit
  import qsys_pio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_raw,
  output logic o_stable
);

  localparam int CW = cnt_w(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_raw;
  logic                   r_stable;

  // Shift the asynchronous input through the synchroniser.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  assign w_raw    = r_sync[SYNC_STAGES-1];
  assign o_stable = r_stable;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    // No filtering: just register the synchronised level.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_stable <= 1'b0;
      else          r_stable <= w_raw;
    end
  end else begin : g_deb
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [CW-1:0] r_cnt;

    // Count clocks of disagreement; accept the new level on the Nth.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
      end else if (w_raw == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_stable <= w_raw;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/qsys_pio_in_irq.sv
// Avalon-MM input PIO with debounce, edge capture,
// interrupt mask and a registered level interrupt.
module qsys_pio_in_irq
  import qsys_pio_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_edgecap;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      w_rdmux;
  logic             w_wr;
  logic             w_unused;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    pio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_raw    (in_port[g]),
      .o_stable (w_stable[g])
    );
  end

  assign w_wr     = chipselect & ~write_n;
  assign w_unused = ^writedata;

  assign w_edge =
    (EDGE_TYPE == EDGE_RISE) ? (w_stable & ~r_prev) :
    (EDGE_TYPE == EDGE_FALL) ? (~w_stable & r_prev) :
    (w_stable ^ r_prev);

  assign w_clr = (w_wr && address == ADDR_EDGECAP) ?
                 writedata[WIDTH-1:0] : '0;

  // Read mux; unused upper bits stay zero.
  always_comb begin
    w_rdmux = '0;
    case (address)
      ADDR_DATA:    w_rdmux[WIDTH-1:0] = w_stable;
      ADDR_DIR:     w_rdmux = '0;
      ADDR_IRQMASK: w_rdmux[WIDTH-1:0] = r_irqmask;
      ADDR_EDGECAP: w_rdmux[WIDTH-1:0] = r_edgecap;
      default:      w_rdmux = '0;
    endcase
  end

  // Edge history, sticky capture (set beats clear), mask.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_edgecap <= '0;
      r_irqmask <= '0;
    end else begin
      r_prev    <= w_stable;
      r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
      if (w_wr && address == ADDR_IRQMASK)
        r_irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Registered read data and interrupt level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= w_rdmux;
      irq      <= |(r_edgecap & r_irqmask);
    end
  end

endmodule

// File: tb/tb_qsys_pio_in_irq.sv
// Randomised bench for qsys_pio_in_irq: two configurations
// driven in lockstep against a history-based reference model.
module tb_qsys_pio_in_irq;

  localparam int W = 10;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rd0, rd1;
  logic          irq0, irq1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  qsys_pio_in_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .irq(irq0)
  );

  qsys_pio_in_irq #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address),
    .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(rd1),
    .in_port(in_port), .irq(irq1)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model. Per instance: input delay line of S samples,
  // last N synchronised samples, and the architectural registers.
  logic [W-1:0] m_dly [2][S];
  logic [W-1:0] m_win [4];
  logic [W-1:0] m_stb [2];
  logic [W-1:0] m_prv [2];
  logic [W-1:0] m_ec  [2];
  logic [W-1:0] m_msk [2];
  logic [31:0]  m_rd  [2];
  logic         m_irq [2];

  function automatic int nd(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  function automatic int et(input int i);
    return (i == 0) ? 0 : 2;
  endfunction

  task automatic mdl_reset();
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < S; k++) m_dly[i][k] = '0;
      m_stb[i] = '0; m_prv[i] = '0; m_ec[i] = '0;
      m_msk[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
    end
    for (int k = 0; k < 4; k++) m_win[k] = '0;
  endtask

  task automatic mdl_step(input int i, input logic [1:0] a,
                          input logic wr, input logic [31:0] wd,
                          input logic [W-1:0] inp);
    logic [W-1:0] raw, ns, ed, clr;
    logic flip;
    int n;
    n = nd(i);
    raw = m_dly[i][0];
    for (int k = 0; k < S - 1; k++) m_dly[i][k] = m_dly[i][k+1];
    m_dly[i][S-1] = inp;
    if (n == 0) begin
      ns = raw;
    end else begin
      for (int k = 0; k < n - 1; k++) m_win[k] = m_win[k+1];
      m_win[n-1] = raw;
      ns = m_stb[i];
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int k = 0; k < n; k++)
          if (m_win[k][b] == m_stb[i][b]) flip = 1'b0;
        if (flip) ns[b] = ~m_stb[i][b];
      end
    end
    case (et(i))
      0:       ed = m_stb[i] & ~m_prv[i];
      1:       ed = ~m_stb[i] & m_prv[i];
      default: ed = m_stb[i] ^ m_prv[i];
    endcase
    clr = (wr && a == 2'd3) ? wd[W-1:0] : '0;
    case (a)
      2'd0:    m_rd[i] = {22'b0, m_stb[i]};
      2'd2:    m_rd[i] = {22'b0, m_msk[i]};
      2'd3:    m_rd[i] = {22'b0, m_ec[i]};
      default: m_rd[i] = '0;
    endcase
    m_irq[i] = |(m_ec[i] & m_msk[i]);
    m_ec[i] = (m_ec[i] & ~clr) | ed;
    if (wr && a == 2'd2) m_msk[i] = wd[W-1:0];
    m_prv[i] = m_stb[i];
    m_stb[i] = ns;
  endtask

  // One bus cycle: drive, clock, update model, compare at negedge.
  task automatic step(input logic [1:0] a, input logic cs,
                      input logic wn, input logic [31:0] wd,
                      input logic [W-1:0] ip);
    address = a; chipselect = cs; write_n = wn;
    writedata = wd; in_port = ip;
    @(posedge clk);
    mdl_step(0, a, cs & ~wn, wd, ip);
    mdl_step(1, a, cs & ~wn, wd, ip);
    @(negedge clk);
    chk("rd0", rd0, m_rd[0]);
    chk("irq0", {31'b0, irq0}, {31'b0, m_irq[0]});
    chk("rd1", rd1, m_rd[1]);
    chk("irq1", {31'b0, irq1}, {31'b0, m_irq[1]});
  endtask

  task automatic rd(input logic [1:0] a, input logic [W-1:0] ip);
    step(a, 1'b1, 1'b1, 32'h0, ip);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input logic [W-1:0] ip);
    step(a, 1'b1, 1'b0, d, ip);
  endtask

  logic [W-1:0] cur;

  initial begin
    mdl_reset();
    in_port = 10'h2A5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_irq0", {31'b0, irq0}, 32'h0);
    reset_n = 1'b1;

    // Reset release with inputs already high.
    repeat (10) rd(2'd0, 10'h2A5);
    rd(2'd0, 10'h2A5);
    chk("data0", rd0, 32'h0000_02A5);
    chk("data1", rd1, 32'h0000_02A5);
    rd(2'd1, 10'h2A5);
    chk("dir", rd0, 32'h0);
    rd(2'd2, 10'h2A5);
    chk("mask_rst", rd0, 32'h0);
    repeat (10) rd(2'd0, 10'h000);
    wr(2'd3, 32'hFFFF_FFFF, 10'h000);
    wr(2'd2, 32'h0000_0001, 10'h000);

    // Short glitch on bit 0 must not be accepted.
    repeat (3) rd(2'd0, 10'h001);
    for (int j = 0; j < 8; j++) begin
      rd(2'd0, 10'h000);
      chk("glitch", {31'b0, rd0[0]}, 32'h0);
    end
    wr(2'd3, 32'h3FF, 10'h000);

    // Clean step: DATA, capture and irq timing.
    for (int j = 1; j <= 8; j++) begin
      rd(2'd0, 10'h001);
      if (j == 6) chk("deb_j6", {31'b0, rd0[0]}, 32'h0);
      if (j == 7) chk("deb_j7", {31'b0, rd0[0]}, 32'h1);
      if (j == 7) chk("irq_j7", {31'b0, irq0}, 32'h0);
      if (j == 8) chk("irq_j8", {31'b0, irq0}, 32'h1);
    end
    wr(2'd3, 32'h1, 10'h001);
    chk("w1c_same", {31'b0, irq0}, 32'h1);
    rd(2'd3, 10'h001);
    chk("w1c_next", {31'b0, irq0}, 32'h0);

    // Mask gating on bit 5.
    wr(2'd2, 32'h0, 10'h001);
    repeat (10) rd(2'd3, 10'h021);
    chk("ec_b5", rd0, 32'h20);
    chk("irq_masked", {31'b0, irq0}, 32'h0);
    wr(2'd2, 32'hFFFF_FC20, 10'h021);
    chk("irq_unmask0", {31'b0, irq0}, 32'h0);
    rd(2'd2, 10'h021);
    chk("irq_unmask1", {31'b0, irq0}, 32'h1);
    rd(2'd2, 10'h021);
    chk("mask_rd", rd0, 32'h20);

    // Clear and new edge on bit 3 in the same clock.
    for (int j = 1; j <= 7; j++) begin
      if (j == 7) wr(2'd3, 32'h8, 10'h029);
      else        rd(2'd0, 10'h029);
    end
    rd(2'd3, 10'h029);
    chk("collide", {31'b0, rd0[3]}, 32'h1);

    // Any-edge, no debounce: two captures on bit 9.
    wr(2'd3, 32'h3FF, 10'h029);
    repeat (5) rd(2'd3, 10'h229);
    chk("any_rise", {31'b0, rd1[9]}, 32'h1);
    wr(2'd3, 32'h200, 10'h229);
    rd(2'd3, 10'h229);
    repeat (5) rd(2'd3, 10'h029);
    chk("any_fall", {31'b0, rd1[9]}, 32'h1);

    // Random traffic.
    cur = 10'h029;
    for (int j = 0; j < 400; j++) begin
      logic [1:0] a;
      logic cs, wn;
      if ($urandom_range(0, 5) == 0)
        cur[$urandom_range(0, W-1)] = ~cur[$urandom_range(0, W-1)];
      if ($urandom_range(0, 9) == 0) cur = W'($urandom);
      a  = 2'($urandom_range(0, 3));
      cs = ($urandom_range(0, 3) != 0);
      wn = ($urandom_range(0, 3) != 0);
      step(a, cs, wn, $urandom, cur);
    end

    // Reset in the middle of a bit-9 pulse.
    wr(2'd2, 32'h3FF, cur);
    cur[9] = ~cur[9];
    repeat (4) rd(2'd3, cur);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rd0", rd0, 32'h0);
    chk("mid_irq0", {31'b0, irq0}, 32'h0);
    chk("mid_rd1", rd1, 32'h0);
    chk("mid_irq1", {31'b0, irq1}, 32'h0);
    mdl_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    rd(2'd3, cur);
    chk("post_ec1", rd1, 32'h0);
    repeat (8) rd(2'd3, cur);
    repeat (8) rd(2'd0, cur);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
